// File: rtl/dmem_mmio_bridge_if.sv
// Core data-memory port plus the TX byte stream, bundled for the dmem/MMIO bridge.
// master = core/consumer side, slave = bridge side.
interface dmem_mmio_bridge_if;
  logic [31:0] dmemaddr;
  logic [31:0] dmemdatain;
  logic [2:0]  dmemop;
  logic        dmemwe;
  logic [31:0] dmemdataout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        err;

  modport master (
    output dmemaddr, dmemdatain, dmemop, dmemwe, tx_ready,
    input  dmemdataout, tx_data, tx_valid, err
  );

  modport slave (
    input  dmemaddr, dmemdatain, dmemop, dmemwe, tx_ready,
    output dmemdataout, tx_data, tx_valid, err
  );
endinterface

// File: rtl/dmem_mmio_bridge.sv
// Data-side slave for the single-cycle RV32I core: word-organised RAM with byte enables,
// plus an MMIO page with a TX byte FIFO, sticky STATUS/err and a free-running cycle counter.
module dmem_mmio_bridge #(
  parameter int unsigned RAM_AW     = 12,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
  input logic               clock,
  input logic               reset,
  dmem_mmio_bridge_if.slave bus
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {
    OP_B = 3'b000, OP_H = 3'b001, OP_W = 3'b010, OP_BU = 3'b100, OP_HU = 3'b101
  } dmem_op_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_BAD} size_e;
  typedef enum logic [3:0] {REG_TXDATA = 4'h0, REG_STATUS = 4'h1, REG_CYCLE = 4'h2} mmio_reg_e;

  logic [3:0][7:0]   ram [(1 << RAM_AW)];
  logic [7:0]        fifo_q [FIFO_DEPTH];
  logic [7:0]        fifo_d [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [31:0]       cycle_q, cycle_d;
  logic              err_q, err_d;

  size_e             size;
  logic              misaligned, bad_access, ram_hit, mmio_hit;
  logic [3:0]        offset;
  logic [RAM_AW-1:0] ram_idx;
  logic [3:0][7:0]   rword, wword;
  logic [3:0]        ram_be;
  logic              full, empty, push, pop, err_set, err_clr;
  logic [31:0]       status;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign ram_hit  = (bus.dmemaddr[31:RAM_AW+2] == '0);
  assign mmio_hit = (bus.dmemaddr[31:6] == MMIO_BASE[31:6]);
  assign offset   = bus.dmemaddr[5:2];
  assign ram_idx  = bus.dmemaddr[RAM_AW+1:2];
  assign rword    = ram[ram_idx];

  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(FIFO_DEPTH));
  assign pop    = !empty && bus.tx_ready;
  assign status = {err_q, 23'b0, full, empty, 6'(count_q)};

  assign bus.tx_valid = !empty;
  assign bus.tx_data  = fifo_q[rd_ptr_q];
  assign bus.err      = err_q;

  always_comb begin
    case (bus.dmemop)
      OP_B, OP_BU: size = SZ_B;
      OP_H, OP_HU: size = SZ_H;
      OP_W:        size = SZ_W;
      default:     size = SZ_BAD;
    endcase
  end

  assign misaligned = ((size == SZ_H) && bus.dmemaddr[0]) ||
                      ((size == SZ_W) && (bus.dmemaddr[1:0] != 2'b00));
  assign bad_access = misaligned || (size == SZ_BAD);

  // Loads are purely combinational and never touch err.
  always_comb begin
    bus.dmemdataout = '0;
    if (!bad_access) begin
      if (ram_hit) begin
        case (size)
          SZ_B:    bus.dmemdataout = {24'b0, rword[bus.dmemaddr[1:0]]};
          SZ_H:    bus.dmemdataout = bus.dmemaddr[1] ? {16'b0, rword[3], rword[2]}
                                                     : {16'b0, rword[1], rword[0]};
          default: bus.dmemdataout = rword;
        endcase
      end else if (mmio_hit && (size == SZ_W)) begin
        case (offset)
          REG_STATUS: bus.dmemdataout = status;
          REG_CYCLE:  bus.dmemdataout = cycle_q;
          default:    bus.dmemdataout = '0;
        endcase
      end
    end
  end

  always_comb begin
    ram_be  = '0;
    wword   = bus.dmemdatain;
    push    = 1'b0;
    err_set = 1'b0;
    err_clr = 1'b0;
    case (size)
      SZ_B:    wword = {4{bus.dmemdatain[7:0]}};
      SZ_H:    wword = {2{bus.dmemdatain[15:0]}};
      default: wword = bus.dmemdatain;
    endcase
    if (bus.dmemwe) begin
      if (bad_access) begin
        err_set = 1'b1;
      end else if (ram_hit) begin
        case (size)
          SZ_B:    ram_be[bus.dmemaddr[1:0]] = 1'b1;
          SZ_H:    ram_be = bus.dmemaddr[1] ? 4'b1100 : 4'b0011;
          default: ram_be = '1;
        endcase
      end else if (mmio_hit) begin
        if (size != SZ_W) begin
          err_set = 1'b1;
        end else begin
          case (offset)
            // A full FIFO still accepts a push when the head leaves in the same cycle.
            REG_TXDATA: if (full && !pop) err_set = 1'b1; else push = 1'b1;
            REG_STATUS: err_clr = bus.dmemdatain[31];
            REG_CYCLE:  ;
            default:    err_set = 1'b1;
          endcase
        end
      end else begin
        err_set = 1'b1;
      end
    end
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (push) fifo_d[wr_ptr_q] = bus.dmemdatain[7:0];
    cycle_d  = cycle_q + 32'd1;
    err_d    = err_set || (err_q && !err_clr);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fifo_q   <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      cycle_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      fifo_q   <= fifo_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      cycle_q  <= cycle_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (ram_be[i]) ram[ram_idx][i] <= wword[i];
    end
  end
endmodule
